// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared types for the float serial transmitter. Holds the
//                packed float word {sign, exponent, significand}, the field
//                widths and the transmitter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_E_W = 3;
    localparam int FP_F_W = 4;

    typedef struct packed {
        logic              sign;
        logic [FP_E_W-1:0] exponent;
        logic [FP_F_W-1:0] significand;
    } fp_word_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp_fifo
//  Description : Small synchronous FIFO. Registered read pointer with the
//                head entry presented combinationally on rdata_o.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                push_i, wdata_i  - write strobe and data (ignored when full)
//                pop_i            - read strobe (ignored when empty)
//                rdata_o          - current head entry
//                full_o, empty_o  - occupancy flags
//                count_o          - number of occupied entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are exactly PTR_W bits wide so they wrap at DEPTH.
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule : fp_fifo
`default_nettype wire

// File: rtl/fp_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fp_serial_tx
//  Description : Buffers converted float words in a FIFO and sends each one
//                as an 8-bit UART-style frame: start, 8 data bits LSB first,
//                optional even parity, stop.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                in_valid, in_ready         - upstream handshake
//                sign, exponent, significand- float word fields
//                tx                         - serial line, idles high
//                busy                       - frame in progress
//                fifo_count                 - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_serial_tx
    import fp_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign,
    input  logic [FP_E_W-1:0]      exponent,
    input  logic [FP_F_W-1:0]      significand,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic              tx_q;
    logic              busy_q;

    fp_word_t          w_in_word;
    logic [7:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_last;

    assign w_in_word   = '{sign: sign, exponent: exponent, significand: significand};
    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign w_baud_last = (baud_q == BAUD_LAST);
    // A word leaves the FIFO either from IDLE or on the last STOP cycle, the
    // latter chaining frames with no idle gap.
    assign w_pop       = !w_empty && ((state_q == ST_IDLE) ||
                                      (state_q == ST_STOP && w_baud_last));

    fp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fp_word_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_in_word),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_START: begin
                    if (w_baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            if (PARITY_EN) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            // Next bit is shift_q[1] since the shift lands this edge.
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_baud_last) begin
                        baud_q  <= '0;
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        baud_q  <= '0;
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase

            // Loading a new frame overrides whatever the state branch chose.
            if (w_pop) begin
                shift_q  <= w_head;
                parity_q <= ^w_head;
                baud_q   <= '0;
                state_q  <= ST_START;
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
            end
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule : fp_serial_tx
`default_nettype wire

// File: tb/tb_fp_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fp_serial_tx
//  Description : Self-checking bench for fp_serial_tx. A frame-level model
//                (word queue plus cycles-left-in-frame counter) predicts the
//                line, busy, ready and occupancy every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_serial_tx;

    localparam int DEPTH  = 4;
    localparam int CPB    = 4;
    localparam int FRAME0 = 11 * CPB;
    localparam int FRAME1 = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       in_ready, tx, busy;
    logic [2:0] fifo_count;

    logic       v1 = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic       rdy1, tx1, busy1;
    logic [2:0] cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_serial_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sign(din[7]), .exponent(din[6:4]), .significand(din[3:0]),
        .tx(tx), .busy(busy), .fifo_count(fifo_count));

    fp_serial_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1),
        .sign(d1[7]), .exponent(d1[6:4]), .significand(d1[3:0]),
        .tx(tx1), .busy(busy1), .fifo_count(cnt1));

    // ---------------- reference model (parity-enabled instance) ----------
    logic [7:0] mq[$];
    int         m_left = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_push = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_left = 0;
            m_push = 1'b0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            if (mq.size() != 0 && m_left <= 1) begin
                m_cur  = mq.pop_front();
                m_left = FRAME0;
            end else if (m_left != 0) begin
                m_left = m_left - 1;
            end
            if (m_push) mq.push_back(din);
        end
    end

    // {tx, busy, in_ready, fifo_count} expected after the latest edge
    function automatic logic [5:0] exp_vec();
        int   slot;
        logic t;
        slot = (FRAME0 - m_left) / CPB;
        if (m_left == 0)    t = 1'b1;
        else if (slot == 0) t = 1'b0;
        else if (slot <= 8) t = m_cur[slot-1];
        else if (slot == 9) t = ^m_cur;
        else                t = 1'b1;
        return {t, (m_left != 0), (mq.size() < DEPTH), 3'(mq.size())};
    endfunction

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx, busy, in_ready, fifo_count} !== 6'b101000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {tx, busy, in_ready, fifo_count}, 6'b101000);
        end
        checks++;
        if ({tx1, busy1, rdy1, cnt1} !== 6'b101000) begin
            failures++;
            $display("FAIL reset_state_np got=%b exp=%b", {tx1, busy1, rdy1, cnt1}, 6'b101000);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [10:0] pat;
        int          busy_cnt = 0;
        pat = {1'b1, 1'b0, 8'h5A, 1'b0};
        in_valid = 1'b1; din = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({tx, busy, fifo_count} !== 5'b10001) begin
            failures++;
            $display("FAIL single_after_push got=%b exp=%b", {tx, busy, fifo_count}, 5'b10001);
        end
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL single_model c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
            checks++;
            if (tx !== ((c < FRAME0) ? pat[c / CPB] : 1'b1)) begin
                failures++;
                $display("FAIL single_bit c=%0d got=%b exp=%b", c, tx, (c < FRAME0) ? pat[c / CPB] : 1'b1);
            end
            if (c == 0) begin
                checks++;
                if (fifo_count !== 3'd0) begin
                    failures++;
                    $display("FAIL single_pop_count got=%0d exp=0", fifo_count);
                end
            end
        end
        checks++;
        if (busy_cnt != FRAME0) begin
            failures++;
            $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, FRAME0);
        end
    endtask

    task automatic test_saturated();
        logic exp1;
        in_valid = 1'b1; din = 8'hFF;
        v1 = 1'b1; d1 = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0; v1 = 1'b0;
        for (int c = 0; c < 46; c++) begin
            @(posedge clk); #1;
            exp1 = (c >= FRAME1) ? 1'b1 : ((c / CPB) == 0 ? 1'b0 : 1'b1);
            checks++;
            if ({tx1, busy1} !== {exp1, (c < FRAME1)}) begin
                failures++;
                $display("FAIL sat_noparity c=%0d got=%b exp=%b", c, {tx1, busy1}, {exp1, (c < FRAME1)});
            end
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL sat_model c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
            if ((c / CPB) == 9) begin
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL sat_parity c=%0d got=%b exp=0", c, tx);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        int         peak = 0;
        int         busy_cnt = 0;
        w[0] = 8'h5A; w[1] = 8'h01; w[2] = 8'h80;
        for (int c = 0; c < 141; c++) begin
            in_valid = (c < 3);
            din      = (c < 3) ? w[c] : 8'h00;
            @(posedge clk); #1;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (busy) busy_cnt++;
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_model c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (peak != 2) begin
            failures++;
            $display("FAIL b2b_peak got=%0d exp=2", peak);
        end
        checks++;
        if (busy_cnt != 3 * FRAME0) begin
            failures++;
            $display("FAIL b2b_no_gap busy_cycles got=%0d exp=%0d", busy_cnt, 3 * FRAME0);
        end
    endtask

    task automatic test_full();
        logic [7:0] w [6];
        logic [7:0] base;
        int         idx = 0;
        int         prev = 0;
        bit         saw_full = 1'b0;
        bit         saw_pop_full = 1'b0;
        base = 8'($urandom);
        for (int i = 0; i < 6; i++) w[i] = base + 8'(i * 29);
        for (int c = 0; c < 300; c++) begin
            in_valid = (idx < 6);
            din      = (idx < 6) ? w[idx] : 8'h00;
            @(posedge clk); #1;
            if (m_push) idx++;
            if (fifo_count == 3'd4) saw_full = 1'b1;
            if (prev == 4 && fifo_count == 3'd3 && in_valid) saw_pop_full = 1'b1;
            prev = int'(fifo_count);
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL full_model c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!(saw_full && saw_pop_full && idx == 6)) begin
            failures++;
            $display("FAIL full_flags got=full%0d/popfull%0d/acc%0d exp=1/1/6", saw_full, saw_pop_full, idx);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 19; c++) begin
            in_valid = (c < 3);
            din      = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_model c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({tx, busy, fifo_count} !== 5'b10000) begin
            failures++;
            $display("FAIL rstmid_abort got=%b exp=%b", {tx, busy, fifo_count}, 5'b10000);
        end
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== 6'b101000) begin
                failures++;
                $display("FAIL rstmid_residual c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, 6'b101000);
            end
        end
    endtask

    task automatic test_simul_push_pop();
        int guard = 0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; din = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        while (m_left != 1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL simul_model g=%0d got=%b exp=%b", guard, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
        end
        checks++;
        if (guard >= 200 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL simul_setup got=count%0d/guard%0d exp=count1", fifo_count, guard);
        end
        in_valid = 1'b1; din = 8'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({tx, busy, fifo_count} !== 5'b01001) begin
            failures++;
            $display("FAIL simul_push_pop got=%b exp=%b", {tx, busy, fifo_count}, 5'b01001);
        end
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL simul_tail c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 700; c++) begin
            in_valid = (c < 500) && ($urandom_range(0, 9) == 0);
            din      = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({tx, busy, in_ready, fifo_count} !== exp_vec()) begin
                failures++;
                $display("FAIL random_model c=%0d got=%b exp=%b", c, {tx, busy, in_ready, fifo_count}, exp_vec());
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturated();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_simul_push_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fp_serial_tx
`default_nettype wire
